// File: rtl/memory_port_arbiter.sv
// -----------------------------------------------------------------------------
// memory_port_arbiter
//
// Shares one single-outstanding memory port between three requesters:
// instruction fetch (i), data access (d) and debug (x). One transaction at a
// time walks IDLE -> ISSUE -> WAIT -> DONE -> IDLE, so back-to-back
// transactions are always separated by at least one dead cycle.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : rotating priority i -> d -> x -> i.
//                                       The requester served last becomes
//                                       lowest priority.
//                           undefined : fixed priority x > d > i, and no
//                                       pointer register exists.
//
// Parameter:
//   TIMEOUT_CYC  WAIT cycles allowed before the access is aborted (1..255).
//
// Ports (all outputs are registered):
//   clk1                 single clock, rising edge
//   start                synchronous active-high reset
//   req_i, addr_i        fetch request / address (fetches never write)
//   req_d, we_d, addr_d, wdata_d   data-port request and fields
//   req_x, we_x, addr_x, wdata_x   debug-port request and fields
//   gnt[2:0]             one-hot grant {x,d,i}, high from ISSUE through WAIT
//   rvalid[2:0]          one-cycle completion pulse {x,d,i}
//   err[2:0]             one-cycle timeout pulse {x,d,i}
//   rdata[31:0]          read data of the last completed read
//   mem_en, mem_we, mem_addr, mem_wdata   memory strobe and fields (ISSUE only)
//   mem_rdy, mem_rdata   memory completion / read data (sampled in WAIT only)
//   busy                 high whenever the FSM is not in IDLE
//   state_dbg[1:0]       current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
//
// Handshake: a requester raises req with its fields stable and keeps them
// until it sees its own rvalid or err bit. A req is only sampled in IDLE, so
// a req that rises and falls while another transaction is running is never
// granted, and dropping req after the grant does not cancel the access. On
// the memory side mem_en is a single-cycle command strobe; the memory answers
// with mem_rdy (plus mem_rdata for reads) at any later cycle, and mem_rdy
// seen during the strobe cycle itself is ignored.
// -----------------------------------------------------------------------------
module memory_port_arbiter #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic        clk1,
   input  logic        start,
   input  logic        req_i,
   input  logic [15:0] addr_i,
   input  logic        req_d,
   input  logic        we_d,
   input  logic [15:0] addr_d,
   input  logic [31:0] wdata_d,
   input  logic        req_x,
   input  logic        we_x,
   input  logic [15:0] addr_x,
   input  logic [31:0] wdata_x,
   output logic [2:0]  gnt,
   output logic [2:0]  rvalid,
   output logic [2:0]  err,
   output logic [31:0] rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_rdy,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // The counter runs 0..TIMEOUT_CYC-1 across the WAIT cycles; the abort
   // fires at the end of the WAIT cycle in which it holds this value.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t      state, state_n;
   logic [2:0]  gnt_n, rvalid_n, err_n;
   logic [31:0] rdata_n;
   logic        mem_en_n, mem_we_n;
   logic [15:0] mem_addr_n;
   logic [31:0] mem_wdata_n;
   logic        busy_n;
   logic        lat_we, lat_we_n;
   logic [7:0]  wait_cnt, wait_cnt_n;
   logic        finish;

   // Arbitration result and the winner's fields.
   logic [2:0]  win;
   logic [15:0] sel_addr;
   logic        sel_we;
   logic [31:0] sel_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Index of the highest-priority requester: 0 = i, 1 = d, 2 = x.
   logic [1:0]  rr_ptr, rr_ptr_n;
`endif

   // --------------------------------------------------------------------------
   // Winner selection (only consumed in IDLE)
   // --------------------------------------------------------------------------
   always_comb begin
      win = 3'b000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      case (rr_ptr)
         2'd0: begin
            if (req_i)      win = 3'b001;
            else if (req_d) win = 3'b010;
            else if (req_x) win = 3'b100;
         end
         2'd1: begin
            if (req_d)      win = 3'b010;
            else if (req_x) win = 3'b100;
            else if (req_i) win = 3'b001;
         end
         default: begin
            if (req_x)      win = 3'b100;
            else if (req_i) win = 3'b001;
            else if (req_d) win = 3'b010;
         end
      endcase
`else
      if (req_x)      win = 3'b100;
      else if (req_d) win = 3'b010;
      else if (req_i) win = 3'b001;
`endif
   end

   // Fetches are always reads and carry no write data.
   always_comb begin
      sel_addr  = addr_i;
      sel_we    = 1'b0;
      sel_wdata = 32'h0;
      if (win[2]) begin
         sel_addr  = addr_x;
         sel_we    = we_x;
         sel_wdata = wdata_x;
      end else if (win[1]) begin
         sel_addr  = addr_d;
         sel_we    = we_d;
         sel_wdata = wdata_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_n     = state;
      gnt_n       = gnt;
      rvalid_n    = 3'b000;
      err_n       = 3'b000;
      rdata_n     = rdata;
      mem_en_n    = 1'b0;
      mem_we_n    = 1'b0;
      mem_addr_n  = 16'h0;
      mem_wdata_n = 32'h0;
      lat_we_n    = lat_we;
      wait_cnt_n  = wait_cnt;
      finish      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_n    = rr_ptr;
`endif

      case (state)
         S_IDLE: begin
            if (win != 3'b000) begin
               state_n     = S_ISSUE;
               gnt_n       = win;
               lat_we_n    = sel_we;
               // The command fields are loaded here so that they are on
               // the memory bus for exactly the ISSUE cycle.
               mem_en_n    = 1'b1;
               mem_we_n    = sel_we;
               mem_addr_n  = sel_addr;
               mem_wdata_n = sel_wdata;
            end
         end

         S_ISSUE: begin
            state_n    = S_WAIT;
            wait_cnt_n = 8'h0;
         end

         S_WAIT: begin
            // mem_rdy is tested first so a response arriving on the timeout
            // cycle still completes normally.
            if (mem_rdy) begin
               rvalid_n = gnt;
               if (!lat_we) rdata_n = mem_rdata;
               finish   = 1'b1;
            end else if (wait_cnt == TO_LAST) begin
               err_n  = gnt;
               finish = 1'b1;
            end else begin
               wait_cnt_n = wait_cnt + 8'h1;
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      if (finish) begin
         state_n = S_DONE;
         gnt_n   = 3'b000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         // The requester after the one just served moves to the top.
         if (gnt[0])      rr_ptr_n = 2'd1;
         else if (gnt[1]) rr_ptr_n = 2'd2;
         else             rr_ptr_n = 2'd0;
`endif
      end

      busy_n = (state_n != S_IDLE);
   end

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk1) begin
      if (start) begin
         state     <= S_IDLE;
         gnt       <= 3'b000;
         rvalid    <= 3'b000;
         err       <= 3'b000;
         rdata     <= 32'h0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 16'h0;
         mem_wdata <= 32'h0;
         busy      <= 1'b0;
         lat_we    <= 1'b0;
         wait_cnt  <= 8'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         rr_ptr    <= 2'd0;
`endif
      end else begin
         state     <= state_n;
         gnt       <= gnt_n;
         rvalid    <= rvalid_n;
         err       <= err_n;
         rdata     <= rdata_n;
         mem_en    <= mem_en_n;
         mem_we    <= mem_we_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         busy      <= busy_n;
         lat_we    <= lat_we_n;
         wait_cnt  <= wait_cnt_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         rr_ptr    <= rr_ptr_n;
`endif
      end
   end

   assign state_dbg = state;

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, max WAIT cycles before abort; legal range 1..255.
REQ-002 clk1  input  1  single clock; all logic on rising edge.
REQ-003 start  input  1  reset: synchronous, active-high.
REQ-004 req_i  input  1  instruction-fetch request.
REQ-005 addr_i  input  16  fetch address (PC count).
REQ-006 req_d / we_d  input  1 each  data-access request / write enable.
REQ-007 addr_d / wdata_d  input  16 / 32  data address / write data.
REQ-008 req_x / we_x  input  1 each  debug-port request / write enable.
REQ-009 addr_x / wdata_x  input  16 / 32  debug address / write data.
REQ-010 gnt  output  3  one-hot grant {x,d,i}.
REQ-011 rvalid  output  3  one-cycle completion pulse per requester {x,d,i}.
REQ-012 err  output  3  one-cycle timeout pulse per requester {x,d,i}.
REQ-013 rdata  output  32  read data from the last completed read.
REQ-014 mem_en / mem_we  output  1 each  memory strobe / write enable.
REQ-015 mem_addr / mem_wdata  output  16 / 32  memory address / write data.
REQ-016 mem_rdy / mem_rdata  input  1 / 32  memory completion / read data.
REQ-017 busy  output  1  high whenever state != IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-019 IDLE: any req high at edge N -> pick winner, latch its addr/we/wdata (fetch we forced 0), gnt[winner]=1, state ISSUE, all visible in cycle N+1.
REQ-020 ISSUE: mem_en=1 for exactly one cycle with latched fields; next state WAIT; mem_rdy during ISSUE ignored.
REQ-021 WAIT: mem_rdy=1 -> rvalid[winner] pulses next cycle, rdata<=mem_rdata on reads only (unchanged on writes), state DONE.
REQ-022 Minimum latency: req sampled at edge N, mem_rdy high in first WAIT cycle -> rvalid high during cycle N+3.
REQ-023 WAIT timeout: 8-bit counter, cleared on entry; reaching TIMEOUT_CYC without mem_rdy -> err[winner] pulses, no rvalid, rdata unchanged, state DONE.
REQ-024 mem_rdy and timeout in the same cycle: mem_rdy wins, no err.
REQ-025 DONE: gnt cleared, mem_* held at 0, state IDLE; at least one dead cycle between transactions.
REQ-026 Requester SHALL hold req and fields until its rvalid/err; a req dropped after grant does not abort the transaction.
REQ-027 A req dropped before being sampled in IDLE is never granted.
REQ-028 Default arbitration: fixed priority x > d > i.
REQ-029 gnt, rvalid, err each at most one bit high; rvalid and err never high together.
REQ-030 mem_en/mem_we/mem_addr/mem_wdata SHALL be 0 outside ISSUE.

Reset
REQ-031 start=1 at any edge: state IDLE; gnt, rvalid, err, mem_en, mem_we, busy = 0; rdata, mem_addr, mem_wdata, latches, counter = 0; RR pointer -> fetch.
REQ-032 start mid-transaction abandons it silently: no rvalid or err for the aborted access.
REQ-033 Requests are ignored while start=1; arbitration resumes on the first edge with start=0.

Configuration
REQ-034 Macro MEM_ARB_ROUND_ROBIN_EN defined: rotating priority; last-served requester becomes lowest, order i->d->x->i; pointer updates only on rvalid/err.
REQ-035 Macro undefined: fixed priority per REQ-028; no pointer register present.

Verification
REQ-036 req_i=1, addr_i=16'h0004, mem_rdy one cycle after mem_en, mem_rdata=32'h12000000 -> gnt=3'b001, mem_addr=16'h0004, rvalid=3'b001 at N+3, rdata=32'h12000000.
REQ-037 req_i, req_d, req_x all high at same edge (fixed) -> grant order x, d, i; each rvalid separated by at least one idle cycle.
REQ-038 Same stimulus with MEM_ARB_ROUND_ROBIN_EN, all held for 6 transactions -> grant order i, d, x, i, d, x.
REQ-039 req_d=1, we_d=1, wdata_d=32'hDEADBEEF, mem_rdy held 0, TIMEOUT_CYC=15 -> mem_we=1 in ISSUE, err=3'b010 after 15 WAIT cycles, no rvalid, rdata unchanged.
REQ-040 start asserted during WAIT of a fetch -> next cycle all outputs 0, state IDLE, no rvalid/err; a new req_i after start=0 completes normally.
